// File: rtl/seq_controller_p.sv
// Fetch/execute sequencer for the accumulator CPU with memory-ready stalls, timeout, sticky halt.
// Optional single-step gating of INST_ADDR is enabled by defining SEQ_CTRL_STEP_EN.
module seq_controller_p #(
  parameter int unsigned OPCODE_W = 3,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                run,
  input  logic                step,
  output logic                mem_rd,
  output logic                load_ir,
  output logic                halt,
  output logic                inc_pc,
  output logic                load_ac,
  output logic                load_pc,
  output logic                mem_wr,
  output logic                bus_err,
  output logic                illegal,
  output logic [3:0]          phase
);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8,
    ERROR      = 4'd9
  } state_t;

  state_t     state, state_nx;
  logic [7:0] wait_cnt;
  logic       op_hlt, op_skz, op_jmp, op_sto, op_alu, op_illegal, stall_pt;

  // Illegal opcodes match none of the decodes below, so they fall through as NOPs.
  assign op_hlt = (opcode == OPCODE_W'(0));
  assign op_skz = (opcode == OPCODE_W'(1));
  assign op_sto = (opcode == OPCODE_W'(6));
  assign op_jmp = (opcode == OPCODE_W'(7));
  assign op_alu = (opcode == OPCODE_W'(2)) || (opcode == OPCODE_W'(3)) ||
                  (opcode == OPCODE_W'(4)) || (opcode == OPCODE_W'(5));

  generate
    if (OPCODE_W > 3) begin : g_wide_op
      assign op_illegal = |opcode[OPCODE_W-1:3];
    end else begin : g_narrow_op
      assign op_illegal = 1'b0;
    end
  endgenerate

`ifndef SEQ_CTRL_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  assign stall_pt = (state == INST_FETCH) || (state == OP_FETCH && op_alu) ||
                    (state == STORE && op_sto);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INST_ADDR;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        wait_cnt <= '0;
      else if (stall_pt && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      INST_ADDR: begin
`ifdef SEQ_CTRL_STEP_EN
        if (step) state_nx = INST_FETCH;
`else
        state_nx = INST_FETCH;
`endif
      end
      INST_FETCH: state_nx = INST_LOAD;
      INST_LOAD:  state_nx = IDLE;
      IDLE:       state_nx = OP_ADDR;
      OP_ADDR:    state_nx = op_hlt ? HALTED : OP_FETCH;
      OP_FETCH:   state_nx = ALU_OP;
      ALU_OP:     state_nx = STORE;
      STORE:      state_nx = INST_ADDR;
      HALTED:     if (run) state_nx = INST_ADDR;
      ERROR:      state_nx = ERROR;
      default:    state_nx = INST_ADDR;
    endcase
    // An unfinished memory access overrides the normal sequence: hold, or give up.
    if (stall_pt && !mem_ready)
      state_nx = (wait_cnt == 8'(WAIT_MAX)) ? ERROR : state;
  end

  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    bus_err = 1'b0;
    illegal = 1'b0;
    case (state)
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc  = 1'b1;
        halt    = op_hlt;
        illegal = op_illegal;
      end
      OP_FETCH: mem_rd = op_alu;
      ALU_OP: begin
        mem_rd  = op_alu;
        load_ac = op_alu;
        inc_pc  = op_skz && zero;
        load_pc = op_jmp;
      end
      STORE: begin
        mem_rd  = op_alu;
        load_ac = op_alu;
        inc_pc  = op_jmp;
        load_pc = op_jmp;
        mem_wr  = op_sto;
      end
      HALTED: halt = 1'b1;
      ERROR: begin
        halt    = 1'b1;
        bus_err = 1'b1;
      end
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_seq_controller_p.sv
// Bench for seq_controller_p: vector table, hand sequences for halt/timeout/reset/step,
// and random instructions checked against per-phase strobe masks derived from the opcode rules.
module tb_seq_controller_p;
  localparam int unsigned OW = 4;
  localparam int unsigned WM = 4;

  logic          clk = 1'b0;
  logic          rst, zero, mem_ready, run, step;
  logic [OW-1:0] opcode;
  logic          mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, bus_err, illegal;
  logic [3:0]    phase;
  logic [8:0]    outs;

  assign outs = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, bus_err, illegal};

  always #5 clk = ~clk;

  seq_controller_p #(.OPCODE_W(OW), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .run(run), .step(step), .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt),
    .inc_pc(inc_pc), .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr),
    .bus_err(bus_err), .illegal(illegal), .phase(phase)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] rd, ir, hl, inc, ac, pc, wr, ill;
    int         cycles;
  } obs_t;

  typedef struct {
    int         opc;
    bit         z;
    int         s_if, s_of, s_st;
    int         cycles;
    logic [7:0] rd, ir, inc, ac, pc, wr, ill;
  } tvec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-phase strobe masks straight from the opcode/phase output rules.
  function automatic obs_t model(input int opc, input bit z, input int s_if, input int s_of,
                                 input int s_st);
    obs_t e;
    bit alu, sto, jmp, skz;
    alu = (opc >= 2) && (opc <= 5);
    sto = (opc == 6);
    jmp = (opc == 7);
    skz = (opc == 1);
    e.cycles = 8 + s_if + (alu ? s_of : 0) + (sto ? s_st : 0);
    e.rd  = 8'h0E | (alu ? 8'hE0 : 8'h00);
    e.ir  = 8'h0C;
    e.hl  = 8'h00;
    e.inc = 8'h10 | ((skz && z) ? 8'h40 : 8'h00) | (jmp ? 8'h80 : 8'h00);
    e.ac  = alu ? 8'hC0 : 8'h00;
    e.pc  = jmp ? 8'hC0 : 8'h00;
    e.wr  = sto ? 8'h80 : 8'h00;
    e.ill = (opc > 7) ? 8'h10 : 8'h00;
    return e;
  endfunction

  // Runs one instruction starting in phase 0; stalls each memory point for s_* cycles.
  task automatic run_instr(input int opc, input bit z, input int s_if, input int s_of,
                           input int s_st, output obs_t o);
    int last, seen, ph;
    bit alu, sto;
    alu = (opc >= 2) && (opc <= 5);
    sto = (opc == 6);
    last = -1;
    seen = 0;
    o = '{default: 0};
    opcode = OW'(opc);
    zero = z;
    for (int c = 0; c < 64; c++) begin
      ph = int'(phase);
      if (c > 0 && ph == 0) return;
      seen = (ph == last) ? seen + 1 : 0;
      last = ph;
      o.cycles++;
      if (ph < 8) begin
        o.rd[ph]  = o.rd[ph]  | mem_rd;
        o.ir[ph]  = o.ir[ph]  | load_ir;
        o.hl[ph]  = o.hl[ph]  | halt;
        o.inc[ph] = o.inc[ph] | inc_pc;
        o.ac[ph]  = o.ac[ph]  | load_ac;
        o.pc[ph]  = o.pc[ph]  | load_pc;
        o.wr[ph]  = o.wr[ph]  | mem_wr;
        o.ill[ph] = o.ill[ph] | illegal;
      end
      if (ph == 1)                mem_ready = (seen >= s_if);
      else if (ph == 5 && alu)    mem_ready = (seen >= s_of);
      else if (ph == 7 && sto)    mem_ready = (seen >= s_st);
      else                        mem_ready = 1'($urandom % 2);
      run = 1'($urandom % 2);
      tick();
    end
    o.cycles = -1;
  endtask

  task automatic cmp_instr(input string tag, input obs_t e, input obs_t o);
    check({tag, " cycles"}, o.cycles, e.cycles);
    check({tag, " mem_rd"}, o.rd, e.rd);
    check({tag, " load_ir"}, o.ir, e.ir);
    check({tag, " halt"}, o.hl, e.hl);
    check({tag, " inc_pc"}, o.inc, e.inc);
    check({tag, " load_ac"}, o.ac, e.ac);
    check({tag, " load_pc"}, o.pc, e.pc);
    check({tag, " mem_wr"}, o.wr, e.wr);
    check({tag, " illegal"}, o.ill, e.ill);
  endtask

  initial begin
    tvec_t tv[9];
    obs_t  o, e;
    int    opc, s_if, s_of, s_st;
    bit    z;

    // opc z if of st cyc   rd     ir     inc    ac     pc     wr     ill
    tv[0] = '{5, 0, 0, 0, 0,  8, 8'hEE, 8'h0C, 8'h10, 8'hC0, 8'h00, 8'h00, 8'h00};
    tv[1] = '{1, 1, 0, 0, 0,  8, 8'h0E, 8'h0C, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[2] = '{1, 0, 0, 0, 0,  8, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[3] = '{7, 1, 0, 0, 0,  8, 8'h0E, 8'h0C, 8'h90, 8'h00, 8'hC0, 8'h00, 8'h00};
    tv[4] = '{6, 0, 0, 0, 0,  8, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h80, 8'h00};
    tv[5] = '{2, 0, 0, 3, 0, 11, 8'hEE, 8'h0C, 8'h10, 8'hC0, 8'h00, 8'h00, 8'h00};
    tv[6] = '{9, 1, 0, 2, 2,  8, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10};
    tv[7] = '{6, 0, 1, 0, 2, 11, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h80, 8'h00};
    tv[8] = '{4, 0, 4, 4, 0, 16, 8'hEE, 8'h0C, 8'h10, 8'hC0, 8'h00, 8'h00, 8'h00};

    rst = 1'b1; run = 1'b0; step = 1'b1; zero = 1'b0; mem_ready = 1'b1; opcode = OW'(5);
    tick();
    tick();
    check("reset phase", phase, 0);
    check("reset outs", outs, 0);
    rst = 1'b0;

    foreach (tv[i]) begin
      run_instr(tv[i].opc, tv[i].z, tv[i].s_if, tv[i].s_of, tv[i].s_st, o);
      check("tbl cycles", o.cycles, tv[i].cycles);
      check("tbl mem_rd", o.rd, tv[i].rd);
      check("tbl load_ir", o.ir, tv[i].ir);
      check("tbl halt", o.hl, 0);
      check("tbl inc_pc", o.inc, tv[i].inc);
      check("tbl load_ac", o.ac, tv[i].ac);
      check("tbl load_pc", o.pc, tv[i].pc);
      check("tbl mem_wr", o.wr, tv[i].wr);
      check("tbl illegal", o.ill, tv[i].ill);
    end

    // HLT, then run after five HALTED cycles
    opcode = OW'(0); mem_ready = 1'b1; run = 1'b0;
    repeat (4) tick();
    check("hlt op_addr phase", phase, 4);
    check("hlt op_addr outs", outs, 9'b001100000);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("halted phase", phase, 8);
      check("halted outs", outs, 9'b001000000);
      if (i == 4) run = 1'b1;
      tick();
    end
    run = 1'b0;
    check("resume phase", phase, 0);
    check("resume outs", outs, 0);

    // Reset while HALTED, with run asserted at the same edge
    repeat (5) tick();
    check("halted again", phase, 8);
    rst = 1'b1; run = 1'b1;
    tick();
    rst = 1'b0; run = 1'b0;
    check("rst halted phase", phase, 0);
    check("rst halted outs", outs, 0);

    // Reset mid-instruction
    opcode = OW'(2); mem_ready = 1'b1;
    repeat (6) tick();
    check("mid alu phase", phase, 6);
    check("mid load_ac", load_ac, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst mid phase", phase, 0);
    check("rst mid outs", outs, 0);

`ifdef SEQ_CTRL_STEP_EN
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("step hold", phase, 0);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step go", phase, 1);
    mem_ready = 1'b1;
    for (int i = 0; i < 12 && phase != 0; i++) tick();
    check("step one instr", phase, 0);
    tick();
    tick();
    check("step hold after", phase, 0);
    step = 1'b1;
`endif

    for (int n = 0; n < 60; n++) begin
      opc  = int'($urandom_range(1, 15));
      z    = 1'($urandom % 2);
      s_if = int'($urandom_range(0, 4));
      s_of = int'($urandom_range(0, 4));
      s_st = int'($urandom_range(0, 4));
      e = model(opc, z, s_if, s_of, s_st);
      run_instr(opc, z, s_if, s_of, s_st, o);
      cmp_instr("rand", e, o);
    end

    // Memory timeout in INST_FETCH
    opcode = OW'(5); mem_ready = 1'b0; run = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("timeout hold", phase, 1);
      tick();
    end
    check("error phase", phase, 9);
    check("error outs", outs, 9'b001000010);
    mem_ready = 1'b1; run = 1'b1;
    repeat (3) tick();
    check("error sticky", phase, 9);
    check("bus_err sticky", bus_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; run = 1'b0;
    check("rst error phase", phase, 0);
    check("rst error outs", outs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
